csa_seq_multiplier: RTL and testbench

//  Iterative unsigned WIDTH x WIDTH multiplier. Partial products accumulate in carry-save form:
//  one or more CSA rows per cycle into sum/carry registers, then a single carry-propagate

---
 rtl/csa_seq_multiplier.sv | 121 ++++++++++++
 tb/tb_csa_seq_multiplier.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/csa_seq_multiplier.sv
// csa_seq_multiplier: iterative WIDTH x WIDTH multiplier, carry-save accumulate then one resolve cycle.
// Define CSA_MUL_SIGNED_EN for two's complement operands (last row subtracted).
module csa_seq_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int N  = WIDTH / ROWS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;
  if (WIDTH < 2 || WIDTH % ROWS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("csa_seq_multiplier: WIDTH must be >=2 and divisible by ROWS_PER_CYCLE");
  end
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] a_q, a_d, sum_q, sum_d, carry_q, carry_d, prod_q, prod_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] fs, fc, pp, ns, a_ext;
  logic          last;
  always_comb begin
`ifdef CSA_MUL_SIGNED_EN
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
`else
    a_ext = {{WIDTH{1'b0}}, a};
`endif
    last = cnt_q == CW'(N - 1);
    fs = sum_q;
    fc = carry_q;
    pp = '0;
    ns = '0;
    // a_q/b_q shift each cycle so row r of this fold always sits at bit r
    for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
      pp = b_q[r] ? a_q << r : '0;
`ifdef CSA_MUL_SIGNED_EN
      if (last && r == ROWS_PER_CYCLE - 1) pp = ~pp;
`endif
      ns = fs ^ fc ^ pp;
      fc = ((fs & fc) | (fs & pp) | (fc & pp)) << 1;
      fs = ns;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ACCUM;
        a_d     = a_ext;
        b_d     = b;
        cnt_d   = '0;
        sum_d   = '0;
        carry_d = '0;
      end
      ACCUM: begin
        sum_d   = fs;
        carry_d = fc;
        a_d     = a_q << ROWS_PER_CYCLE;
        b_d     = b_q >> ROWS_PER_CYCLE;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? RESOLVE : ACCUM;
      end
      RESOLVE: begin
`ifdef CSA_MUL_SIGNED_EN
        prod_d = sum_q + carry_q + PW'(1);
`else
        prod_d = sum_q + carry_q;
`endif
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      carry_d = '0;
      prod_d  = prod_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == ACCUM || state_q == RESOLVE;
  assign product   = prod_q;
endmodule

// File: tb/tb_csa_seq_multiplier.sv
// tb_csa_seq_multiplier: two lanes (ROWS_PER_CYCLE 1 and 2) checked every cycle against a behavioural model.
module tb_csa_seq_multiplier;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] in_ready_w, out_valid_w, busy_w;
  logic [2*W-1:0] product_w [2];
  int checks = 0, fails = 0;
  int rem [2];
  bit done_m [2];
  logic [2*W-1:0] pend_m [2], prod_m [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_lane
    csa_seq_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(g + 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[g]),
      .a(a), .b(b), .out_valid(out_valid_w[g]), .out_ready(out_ready), .product(product_w[g]),
      .busy(busy_w[g]));
  end
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
`ifdef CSA_MUL_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return 16'(sx * sy);
  endfunction
  // transaction-level model: remaining cycles until the product appears, then hold until taken
  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        rem[g] <= 0; done_m[g] <= 0; prod_m[g] <= '0;
      end else if (flush) begin
        rem[g] <= 0; done_m[g] <= 0;
      end else if (rem[g] == 0 && !done_m[g]) begin
        if (in_valid) begin rem[g] <= W / (g + 1) + 1; pend_m[g] <= ref_mul(a, b); end
      end else if (rem[g] > 0) begin
        rem[g] <= rem[g] - 1;
        if (rem[g] == 1) begin done_m[g] <= 1; prod_m[g] <= pend_m[g]; end
      end else if (out_ready) done_m[g] <= 0;
    end
  task automatic chk(input string nm, input int g, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s lane%0d got=%h exp=%h t=%0t", nm, g, got, exp, $time);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("in_ready", g, 16'(in_ready_w[g]), 16'(rem[g] == 0 && !done_m[g]));
        chk("busy", g, 16'(busy_w[g]), 16'(rem[g] > 0));
        chk("out_valid", g, 16'(out_valid_w[g]), 16'(done_m[g]));
        chk("product", g, product_w[g], prod_m[g]);
      end
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (in_ready_w != 2'b11 && n < 50) begin @(negedge clk); n++; end
    if (in_ready_w != 2'b11) chk("idle_timeout", 0, 16'(in_ready_w), 16'h3);
  endtask
  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    wait_idle();
    in_valid = 1; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0; a = 8'($urandom); b = 8'($urandom);
  endtask
  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] lit, input int hold);
    int lat = 0, lat0 = 0, lat1 = 0;
    out_ready = 0;
    accept(x, y);
    while (lat < 40 && (lat0 == 0 || lat1 == 0)) begin
      @(negedge clk); lat++;
      if (out_valid_w[0] && lat0 == 0) lat0 = lat;
      if (out_valid_w[1] && lat1 == 0) lat1 = lat;
    end
    chk("latency", 0, 16'(lat0), 16'(W + 2));
    chk("latency", 1, 16'(lat1), 16'(W / 2 + 2));
    chk("model_lit", 0, prod_m[0], lit);
    chk("product_lit", 0, product_w[0], lit);
    chk("product_lit", 1, product_w[1], lit);
    repeat (hold) @(negedge clk);
    chk("held_product", 0, product_w[0], lit);
    chk("held_valid", 0, 16'(out_valid_w), 16'h3);
    out_ready = 1;
    @(negedge clk);
    chk("release_ready", 0, 16'(in_ready_w), 16'h3);
    out_ready = 0;
  endtask
  initial begin
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, 16'(in_ready_w), 16'h3);
    chk("rst_out_valid", 0, 16'(out_valid_w), 16'h0);
    chk("rst_busy", 0, 16'(busy_w), 16'h0);
    chk("rst_product", 0, product_w[0] | product_w[1], 16'h0);
    rst_n = 1;
`ifdef CSA_MUL_SIGNED_EN
    op(8'd13, 8'd11, 16'h008F, 0);
    op(8'hFF, 8'hFF, 16'h0001, 5);
    op(8'h80, 8'h7F, 16'hC080, 0);
    op(8'd200, 8'd3, 16'hFF58, 2);
`else
    op(8'd13, 8'd11, 16'h008F, 0);
    op(8'hFF, 8'hFF, 16'hFE01, 5);
    op(8'h80, 8'h7F, 16'h3F80, 0);
    op(8'd200, 8'd3, 16'h0258, 2);
`endif
    // abort mid-accumulate with flush, then with reset
    accept(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush_idle", 0, 16'(in_ready_w), 16'h3);
    chk("flush_busy", 0, 16'(busy_w), 16'h0);
    chk("flush_valid", 0, 16'(out_valid_w), 16'h0);
    op(8'h00, 8'h7F, 16'h0000, 0);
    accept(8'hA5, 8'h3C);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("rst_mid_idle", 0, 16'(in_ready_w), 16'h3);
    chk("rst_mid_product", 0, product_w[0] | product_w[1], 16'h0);
    op(8'd13, 8'd11, 16'h008F, 1);
    // random traffic: inputs change every cycle, including while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 40) == 0;
      rst_n     = ($urandom % 300) != 0;
    end
    @(negedge clk);
    rst_n = 1; flush = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
